// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// instruction field codes, ALU operation codes and operand-select codes.
package mc_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MRTYPE   = 4'd2,
        ST_MALUIMM  = 4'd3,
        ST_LW       = 4'd4,
        ST_SW       = 4'd5,
        ST_BENEQ    = 4'd6,
        ST_J        = 4'd7,
        ST_JAL      = 4'd8,
        ST_JR       = 4'd9,
        ST_BPCINC   = 4'd10,
        ST_REGPCINC = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    // Opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes (inst[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU operations
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Second ALU operand select
    localparam logic [2:0] SEL2_RT      = 3'b000;
    localparam logic [2:0] SEL2_FOUR    = 3'b001;
    localparam logic [2:0] SEL2_ZERO    = 3'b010;
    localparam logic [2:0] SEL2_OFFSET  = 3'b011;
    localparam logic [2:0] SEL2_IMM     = 3'b100;
    localparam logic [2:0] SEL2_TRAPVEC = 3'b101;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // True for the R-type functions executed by the ALU
    function automatic logic funct_is_alu(input logic [5:0] funct);
        return funct inside {FN_ADD, FN_SUB, FN_SLT, FN_OR, FN_AND, FN_NOR};
    endfunction

    // ALU operation for an R-type function code
    function automatic logic [3:0] funct_aluop(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_SLT:  return ALU_SLT;
            FN_OR:   return ALU_OR;
            FN_AND:  return ALU_AND;
            FN_NOR:  return ALU_NOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_wait.sv
// mc_wait_timer: counts cycles spent waiting for a memory acknowledge.
// The count restarts on 'start'; 'expired' flags the limit-th waiting cycle
// when no acknowledge arrives in it. A limit of zero never expires.
module mc_wait_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ack,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             at_limit;

    // count_reg holds the number of unacknowledged cycles already spent
    assign at_limit = (limit != '0) && (count_reg == limit - ONE);
    assign expired  = at_limit && !ack;

    // Clear on start, otherwise advance on each unacknowledged cycle and
    // saturate so an idle counter never wraps into a false expiry
    always_comb begin
        count_next = count_reg;
        if (start) begin
            count_next = '0;
        end else if (!ack && !at_limit) begin
            count_next = count_reg + ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle CPU control FSM. Drives datapath enables and
// selects, traps on illegal instructions and on memory bus timeouts.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 8,
    parameter int EN_JAL      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        aluzero,
    input  logic        mem_ack,
    output logic        wpc,
    output logic        wins,
    output logic        wmem,
    output logic        wreg,
    output logic        mem_req,
    output logic        selmemaddr,
    output logic        selext,
    output logic        selalu1,
    output logic [2:0]  selalu2,
    output logic [3:0]  aluop,
    output logic [1:0]  selregwd,
    output logic [1:0]  selregaddr,
    output logic        trap,
    output logic [1:0]  cause,
    output logic [3:0]  state_o
);

    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT);

    state_t      state_reg, state_next;
    logic [1:0]  cause_reg, cause_next;
    logic        timer_start;
    logic        timer_expired;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        unused_inst_bits;

    assign opcode           = inst[31:26];
    assign funct            = inst[5:0];
    assign unused_inst_bits = ^inst[25:6];
    assign cause            = cause_reg;
    assign state_o          = state_reg;

    // Restart the wait count whenever a memory-waiting state is entered
    assign timer_start = (state_next != state_reg) &&
                         (state_next inside {ST_FETCH, ST_LW, ST_SW});

    mc_wait_timer #(
        .WIDTH(TW)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (timer_start),
        .ack     (mem_ack),
        .limit   (LIMIT),
        .expired (timer_expired)
    );

    // State and latched trap cause
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_FETCH;
            cause_reg <= CAUSE_NONE;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
        end
    end

    // Next-state logic and per-state datapath controls
    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        wpc        = 1'b0;
        wins       = 1'b0;
        wmem       = 1'b0;
        wreg       = 1'b0;
        mem_req    = 1'b0;
        selmemaddr = 1'b0;
        selext     = 1'b0;
        selalu1    = 1'b0;
        selalu2    = SEL2_RT;
        aluop      = ALU_AND;
        selregwd   = 2'b00;
        selregaddr = 2'b00;
        trap       = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    wins       = 1'b1;
                    state_next = ST_DECODE;
                end else if (timer_expired) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                state_next = ST_TRAP;
                cause_next = CAUSE_ILLEGAL;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            state_next = ST_JR;
                            cause_next = cause_reg;
                        end else if (funct_is_alu(funct)) begin
                            state_next = ST_MRTYPE;
                            cause_next = cause_reg;
                        end
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        state_next = ST_MALUIMM;
                        cause_next = cause_reg;
                    end
                    OP_LW: begin
                        state_next = ST_LW;
                        cause_next = cause_reg;
                    end
                    OP_SW: begin
                        state_next = ST_SW;
                        cause_next = cause_reg;
                    end
                    OP_BEQ, OP_BNE: begin
                        state_next = ST_BENEQ;
                        cause_next = cause_reg;
                    end
                    OP_J: begin
                        state_next = ST_J;
                        cause_next = cause_reg;
                    end
                    OP_JAL: begin
                        if (EN_JAL != 0) begin
                            state_next = ST_JAL;
                            cause_next = cause_reg;
                        end
                    end
                    default: ;
                endcase
            end
            ST_MRTYPE: begin
                wreg       = 1'b1;
                aluop      = funct_aluop(funct);
                state_next = ST_REGPCINC;
            end
            ST_MALUIMM: begin
                wreg       = 1'b1;
                selalu2    = SEL2_IMM;
                selregaddr = 2'b01;
                case (opcode)
                    OP_ANDI: begin
                        aluop  = ALU_AND;
                        selext = 1'b1;
                    end
                    OP_ORI: begin
                        aluop  = ALU_OR;
                        selext = 1'b1;
                    end
                    default: aluop = ALU_ADD;
                endcase
                state_next = ST_REGPCINC;
            end
            ST_LW, ST_SW: begin
                selalu2    = SEL2_IMM;
                aluop      = ALU_ADD;
                selmemaddr = 1'b1;
                mem_req    = 1'b1;
                // A store holds its write strobe except in a timeout cycle
                wmem       = (state_reg == ST_SW) && !timer_expired;
                if (mem_ack) begin
                    if (state_reg == ST_LW) begin
                        wreg       = 1'b1;
                        selregwd   = 2'b01;
                        selregaddr = 2'b01;
                    end
                    state_next = ST_REGPCINC;
                end else if (timer_expired) begin
                    state_next = ST_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_BENEQ: begin
                selalu2 = SEL2_RT;
                aluop   = ALU_SUB;
                if (((opcode == OP_BEQ) && aluzero) || ((opcode == OP_BNE) && !aluzero)) begin
                    state_next = ST_BPCINC;
                end else begin
                    state_next = ST_REGPCINC;
                end
            end
            ST_JAL: begin
                selalu1    = 1'b1;
                selalu2    = SEL2_FOUR;
                aluop      = ALU_ADD;
                selregaddr = 2'b10;
                wreg       = 1'b1;
                state_next = ST_J;
            end
            ST_J, ST_BPCINC: begin
                selalu1    = 1'b1;
                selalu2    = SEL2_OFFSET;
                aluop      = ALU_ADD;
                wpc        = 1'b1;
                state_next = ST_FETCH;
            end
            ST_JR: begin
                selalu2    = SEL2_ZERO;
                aluop      = ALU_ADD;
                wpc        = 1'b1;
                state_next = ST_FETCH;
            end
            ST_REGPCINC: begin
                selalu1    = 1'b1;
                selalu2    = SEL2_FOUR;
                aluop      = ALU_ADD;
                wpc        = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                selalu2    = SEL2_TRAPVEC;
                aluop      = ALU_ADD;
                wpc        = 1'b1;
                trap       = 1'b1;
                state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control: each instruction is expanded by a
// transaction-level model into the expected per-cycle control words.
`timescale 1ns/1ps
module tb_mc_control;
    import mc_control_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic       wpc;
        logic       wins;
        logic       wmem;
        logic       wreg;
        logic       mem_req;
        logic       selmemaddr;
        logic       selext;
        logic       selalu1;
        logic [2:0] selalu2;
        logic [3:0] aluop;
        logic [1:0] selregwd;
        logic [1:0] selregaddr;
        logic       trap;
        logic [1:0] cause;
    } ctl_t;

    typedef struct {
        logic   ack;
        ctl_t   ctl;
        state_t st;
    } cyc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] inst = '0;
    logic        aluzero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        wpc, wins, wmem, wreg, mem_req, selmemaddr, selext, selalu1;
    logic [2:0]  selalu2;
    logic [3:0]  aluop;
    logic [1:0]  selregwd, selregaddr;
    logic        trap;
    logic [1:0]  cause;
    logic [3:0]  state_o;
    ctl_t        got_ctl;

    int          n_tests = 0;
    int          n_fail  = 0;
    cyc_t        exp_q[$];
    logic [1:0]  m_cause = 2'b00;

    always #5 clk = ~clk;

    mc_control #(
        .MEM_TIMEOUT(TO),
        .EN_JAL     (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .inst       (inst),
        .aluzero    (aluzero),
        .mem_ack    (mem_ack),
        .wpc        (wpc),
        .wins       (wins),
        .wmem       (wmem),
        .wreg       (wreg),
        .mem_req    (mem_req),
        .selmemaddr (selmemaddr),
        .selext     (selext),
        .selalu1    (selalu1),
        .selalu2    (selalu2),
        .aluop      (aluop),
        .selregwd   (selregwd),
        .selregaddr (selregaddr),
        .trap       (trap),
        .cause      (cause),
        .state_o    (state_o)
    );

    assign got_ctl = {wpc, wins, wmem, wreg, mem_req, selmemaddr, selext, selalu1,
                      selalu2, aluop, selregwd, selregaddr, trap, cause};

    // ---------------- reference model ----------------
    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.cause = m_cause;
        return c;
    endfunction

    task automatic push(input logic ack, input ctl_t c, input state_t s);
        cyc_t e;
        e.ack = ack;
        e.ctl = c;
        e.st  = s;
        exp_q.push_back(e);
    endtask

    task automatic push_trap(input logic [1:0] cz);
        ctl_t c;
        m_cause   = cz;
        c         = idle();
        c.selalu2 = 3'b101;
        c.aluop   = 4'b0010;
        c.wpc     = 1'b1;
        c.trap    = 1'b1;
        push(1'b0, c, ST_TRAP);
    endtask

    task automatic push_pcinc();
        ctl_t c;
        c         = idle();
        c.selalu1 = 1'b1;
        c.selalu2 = 3'b001;
        c.aluop   = 4'b0010;
        c.wpc     = 1'b1;
        push(1'b0, c, ST_REGPCINC);
    endtask

    task automatic push_jump(input state_t s);
        ctl_t c;
        c         = idle();
        c.selalu1 = 1'b1;
        c.selalu2 = 3'b011;
        c.aluop   = 4'b0010;
        c.wpc     = 1'b1;
        push(1'b0, c, s);
    endtask

    // Fetch with d wait cycles before the acknowledge
    task automatic fetch_phase(input int d, output bit trapped);
        ctl_t c;
        bit   to;
        int   n;
        to = (TO > 0) && (d >= TO);
        n  = to ? TO : d + 1;
        for (int k = 0; k < n; k++) begin
            c         = idle();
            c.mem_req = 1'b1;
            c.wins    = !to && (k == d);
            push(!to && (k == d), c, ST_FETCH);
        end
        if (to) push_trap(2'b10);
        trapped = to;
    endtask

    // Data access with d wait cycles before the acknowledge
    task automatic mem_phase(input bit is_lw, input int d, output bit trapped);
        ctl_t c;
        bit   to;
        bit   ackcyc;
        int   n;
        to = (TO > 0) && (d >= TO);
        n  = to ? TO : d + 1;
        for (int k = 0; k < n; k++) begin
            ackcyc       = !to && (k == d);
            c            = idle();
            c.selalu2    = 3'b100;
            c.aluop      = 4'b0010;
            c.selmemaddr = 1'b1;
            c.mem_req    = 1'b1;
            if (is_lw) begin
                if (ackcyc) begin
                    c.wreg       = 1'b1;
                    c.selregwd   = 2'b01;
                    c.selregaddr = 2'b01;
                end
            end else begin
                c.wmem = !(to && (k == n - 1));
            end
            push(ackcyc, c, is_lw ? ST_LW : ST_SW);
        end
        if (to) push_trap(2'b10);
        trapped = to;
    endtask

    function automatic logic [4:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 5'b1_0010;
            6'b100010: return 5'b1_0110;
            6'b101010: return 5'b1_0111;
            6'b100101: return 5'b1_0001;
            6'b100100: return 5'b1_0000;
            6'b100111: return 5'b1_1100;
            default:   return 5'b0_0000;
        endcase
    endfunction

    // Expand one instruction into its expected cycle sequence
    task automatic build(input logic [31:0] i, input logic az, input int fd, input int md);
        ctl_t       c;
        bit         tr;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] ra;
        op = i[31:26];
        fn = i[5:0];
        fetch_phase(fd, tr);
        if (tr) return;
        push(1'b0, idle(), ST_DECODE);
        ra = r_alu(fn);
        if (op == 6'b000000 && fn == 6'b001000) begin
            c         = idle();
            c.selalu2 = 3'b010;
            c.aluop   = 4'b0010;
            c.wpc     = 1'b1;
            push(1'b0, c, ST_JR);
        end else if (op == 6'b000000 && ra[4]) begin
            c       = idle();
            c.wreg  = 1'b1;
            c.aluop = ra[3:0];
            push(1'b0, c, ST_MRTYPE);
            push_pcinc();
        end else if (op == 6'b001000 || op == 6'b001100 || op == 6'b001101) begin
            c            = idle();
            c.wreg       = 1'b1;
            c.selalu2    = 3'b100;
            c.selregaddr = 2'b01;
            c.aluop      = (op == 6'b001000) ? 4'b0010 : (op == 6'b001100) ? 4'b0000 : 4'b0001;
            c.selext     = (op != 6'b001000);
            push(1'b0, c, ST_MALUIMM);
            push_pcinc();
        end else if (op == 6'b100011 || op == 6'b101011) begin
            mem_phase(op == 6'b100011, md, tr);
            if (!tr) push_pcinc();
        end else if (op == 6'b000100 || op == 6'b000101) begin
            c       = idle();
            c.aluop = 4'b0110;
            push(1'b0, c, ST_BENEQ);
            if ((op == 6'b000100) ? az : !az) push_jump(ST_BPCINC);
            else push_pcinc();
        end else if (op == 6'b000010) begin
            push_jump(ST_J);
        end else if (op == 6'b000011) begin
            c            = idle();
            c.selalu1    = 1'b1;
            c.selalu2    = 3'b001;
            c.aluop      = 4'b0010;
            c.selregaddr = 2'b10;
            c.wreg       = 1'b1;
            push(1'b0, c, ST_JAL);
            push_jump(ST_J);
        end else begin
            push_trap(2'b01);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle
    task automatic step(input logic [31:0] i, input logic az, input logic ack);
        @(negedge clk);
        inst    = i;
        aluzero = az;
        mem_ack = ack;
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ctl_t c;
        cyc_t e;
        for (int k = 0; k < 2; k++) begin
            step(32'h0, 1'b0, 1'b0);
            c         = idle();
            c.mem_req = 1'b1;
            n_tests++;
            if (got_ctl !== c || state_o !== ST_FETCH) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got ctl=%06h state=%0d, expected ctl=%06h state=%0d",
                         k, got_ctl, state_o, c, ST_FETCH);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
        build(32'h012A4020, 1'b0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            step(32'h012A4020, 1'b0, e.ack);
            n_tests++;
            if (got_ctl !== e.ctl || state_o !== e.st) begin
                n_fail++;
                $display("FAIL reset_release cyc%0d: got ctl=%06h state=%0d, expected ctl=%06h state=%0d",
                         k, got_ctl, state_o, e.ctl, e.st);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] d_inst [10];
        logic        d_az   [10];
        int          d_fd   [10];
        int          d_md   [10];
        cyc_t        e;
        d_inst = '{32'h012A4020, 32'h8D280004, 32'h11090003, 32'h15090003, 32'hFC000000,
                   32'h0C000010, 32'hAD280008, 32'h3528FFFF, 32'h03E00008, 32'h0000003F};
        d_az   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        d_fd   = '{0, 0, 0, 0, 1, 0, 1, 2, 0, 0};
        d_md   = '{0, 3, 0, 0, 0, 0, 2, 0, 0, 0};
        for (int t = 0; t < 10; t++) begin
            build(d_inst[t], d_az[t], d_fd[t], d_md[t]);
            for (int k = 0; exp_q.size() > 0; k++) begin
                e = exp_q.pop_front();
                step(d_inst[t], d_az[t], e.ack);
                n_tests++;
                if (got_ctl !== e.ctl || state_o !== e.st) begin
                    n_fail++;
                    $display("FAIL directed inst=%08h cyc%0d: got ctl=%06h state=%0d, expected ctl=%06h state=%0d",
                             d_inst[t], k, got_ctl, state_o, e.ctl, e.st);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] t_inst [6];
        int          t_fd   [6];
        int          t_md   [6];
        cyc_t        e;
        t_inst = '{32'h012A4020, 32'h012A4020, 32'h8D280004, 32'hAD280008, 32'hAD280008, 32'h8D280004};
        t_fd   = '{TO, TO - 1, 0, 0, 0, 0};
        t_md   = '{0, 0, TO, TO, TO - 1, TO - 1};
        for (int t = 0; t < 6; t++) begin
            build(t_inst[t], 1'b0, t_fd[t], t_md[t]);
            for (int k = 0; exp_q.size() > 0; k++) begin
                e = exp_q.pop_front();
                step(t_inst[t], 1'b0, e.ack);
                n_tests++;
                if (got_ctl !== e.ctl || state_o !== e.st) begin
                    n_fail++;
                    $display("FAIL timeout case%0d cyc%0d: got ctl=%06h state=%0d, expected ctl=%06h state=%0d",
                             t, k, got_ctl, state_o, e.ctl, e.st);
                end
            end
        end
    endtask

    task automatic test_reset_mid_lw();
        ctl_t c;
        cyc_t e;
        build(32'h8D280004, 1'b0, 0, 3);
        // FETCH, DECODE and two waiting LW cycles, then reset mid-access
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            step(32'h8D280004, 1'b0, e.ack);
            n_tests++;
            if (got_ctl !== e.ctl || state_o !== e.st) begin
                n_fail++;
                $display("FAIL mid_lw_pre cyc%0d: got ctl=%06h state=%0d, expected ctl=%06h state=%0d",
                         k, got_ctl, state_o, e.ctl, e.st);
            end
        end
        exp_q.delete();
        #1 reset = 1'b0;
        m_cause = 2'b00;
        #1;
        c         = idle();
        c.mem_req = 1'b1;
        n_tests++;
        if (got_ctl !== c || state_o !== ST_FETCH) begin
            n_fail++;
            $display("FAIL mid_lw_async: got ctl=%06h state=%0d, expected ctl=%06h state=%0d",
                     got_ctl, state_o, c, ST_FETCH);
        end
        step(32'h8D280004, 1'b0, 1'b1);
        c.wins = 1'b1;
        n_tests++;
        if (got_ctl !== c || state_o !== ST_FETCH) begin
            n_fail++;
            $display("FAIL mid_lw_held: got ctl=%06h state=%0d, expected ctl=%06h state=%0d",
                     got_ctl, state_o, c, ST_FETCH);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        build(32'h8D280004, 1'b0, 0, 1);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            step(32'h8D280004, 1'b0, e.ack);
            n_tests++;
            if (got_ctl !== e.ctl || state_o !== e.st) begin
                n_fail++;
                $display("FAIL mid_lw_after cyc%0d: got ctl=%06h state=%0d, expected ctl=%06h state=%0d",
                         k, got_ctl, state_o, e.ctl, e.st);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] i;
        logic [5:0]  fn;
        logic        az;
        int          fd, md;
        cyc_t        e;
        for (int t = 0; t < 60; t++) begin
            r  = $urandom();
            az = 1'($urandom_range(0, 1));
            fd = int'($urandom_range(0, TO + 1));
            md = int'($urandom_range(0, TO + 1));
            case ($urandom_range(0, 13))
                0: begin
                    case ($urandom_range(0, 5))
                        0:       fn = 6'b100000;
                        1:       fn = 6'b100010;
                        2:       fn = 6'b101010;
                        3:       fn = 6'b100101;
                        4:       fn = 6'b100100;
                        default: fn = 6'b100111;
                    endcase
                    i = {6'b000000, r[25:6], fn};
                end
                1:       i = {6'b000000, r[25:6], 6'b001000};
                2:       i = {6'b000000, r[25:0]};
                3:       i = {6'b001000, r[25:0]};
                4:       i = {6'b001100, r[25:0]};
                5:       i = {6'b001101, r[25:0]};
                6:       i = {6'b100011, r[25:0]};
                7:       i = {6'b101011, r[25:0]};
                8:       i = {6'b000100, r[25:0]};
                9:       i = {6'b000101, r[25:0]};
                10:      i = {6'b000010, r[25:0]};
                11:      i = {6'b000011, r[25:0]};
                12:      i = r;
                default: i = {6'b111111, r[25:0]};
            endcase
            build(i, az, fd, md);
            for (int k = 0; exp_q.size() > 0; k++) begin
                e = exp_q.pop_front();
                step(i, az, e.ack);
                n_tests++;
                if (got_ctl !== e.ctl || state_o !== e.st) begin
                    n_fail++;
                    $display("FAIL random t%0d inst=%08h az=%0d fd=%0d md=%0d cyc%0d: got ctl=%06h state=%0d, expected ctl=%06h state=%0d",
                             t, i, az, fd, md, k, got_ctl, state_o, e.ctl, e.st);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid_lw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8: memory wait cycles before bus-error trap; 0 disables the timeout.
REQ-002 Parameter EN_JAL, default 1: 1 decodes JAL; 0 treats opcode 000011 as illegal.
REQ-003 Ports, in order: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- inst  in  32  current instruction register; opcode=[31:26], funct=[5:0].
- aluzero  in  1  ALU zero flag, sampled in BENEQ.
- mem_ack  in  1  memory completes the current request this cycle.
- wpc, wins, wmem, wreg  out  1 each  PC, IR, memory and register-file write enables.
- mem_req  out  1  memory request.
- selmemaddr  out  1  0=PC, 1=ALU result.
- selext  out  1  0=sign-extend, 1=zero-extend.
- selalu1  out  1  0=rs, 1=PC.
- selalu2  out  3  000 rt, 001 const 4, 010 zero, 011 branch/jump offset, 100 immediate, 101 trap vector.
- aluop  out  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1100 nor.
- selregwd  out  2  00 ALU, 01 memory data.
- selregaddr  out  2  00 rd, 01 rt, 10 r31.
- trap  out  1  one-cycle pulse on TRAP entry.
- cause  out  2  00 none, 01 illegal instruction, 10 bus timeout; held until the next trap or reset.
- state_o  out  4  current state encoding, for debug.

Function
REQ-004 States: FETCH, DECODE, MRTYPE, MALUIMM, LW, SW, BENEQ, J, JAL, JR, BPCINC, REGPCINC, TRAP.
REQ-005 FETCH behaviour:
- mem_req=1, selmemaddr=0.
- wins=1 only in the cycle mem_ack=1.
- Stays in FETCH until mem_ack=1, then goes to DECODE.
REQ-006 DECODE routing, one cycle:
- opcode 0, funct 001000 -> JR.
- opcode 0, funct in {add, sub, slt, or, and, nor} -> MRTYPE.
- opcode 0, any other funct -> TRAP, cause 01.
- addi, andi, ori -> MALUIMM.
- 100011 -> LW; 101011 -> SW.
- 000100 or 000101 -> BENEQ.
- 000010 -> J; 000011 -> JAL when EN_JAL=1.
- any other opcode -> TRAP, cause 01.
REQ-007 MRTYPE: wreg=1, selalu2=000, selregaddr=00, aluop from funct per REQ-003; next state REGPCINC.
REQ-008 MALUIMM: wreg=1, selalu2=100, selregaddr=01, aluop add/and/or; selext=0 for addi, 1 for andi/ori; next state REGPCINC.
REQ-009 LW and SW, shared settings: selalu2=100, selext=0, aluop add, selmemaddr=1, mem_req=1 until mem_ack.
- LW: wreg=1, selregwd=01, selregaddr=01, asserted only in the ack cycle.
- SW: wmem=1 on every cycle of the state.
- Both go to REGPCINC after ack.
REQ-010 BENEQ: selalu2=000, aluop sub.
- Next state BPCINC when (opcode 000100 and aluzero=1) or (opcode 000101 and aluzero=0).
- Otherwise next state REGPCINC.
REQ-011 JAL: selalu1=1, selalu2=001, aluop add, selregaddr=10, selregwd=00, wreg=1 (r31 = PC+4); next state J.
REQ-012 J and BPCINC: selalu1=1, selalu2=011, aluop add, wpc=1.
REQ-013 JR: selalu1=0, selalu2=010, aluop add, wpc=1.
REQ-014 REGPCINC: selalu1=1, selalu2=001, aluop add, wpc=1.
REQ-015 J, JR, BPCINC and REGPCINC all go to FETCH.
REQ-016 TRAP: selalu2=101, aluop add, selalu1=0, wpc=1, trap=1; next state FETCH.
REQ-017 Bus timeout:
- A wait counter clears on entry to FETCH, LW or SW and counts cycles without mem_ack.
- When MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT, the next state is TRAP, cause 10, and no write enable is asserted in that cycle.
- mem_ack arriving in the limit cycle wins over the timeout.
REQ-018 Every output not listed for a state is 0.

Reset
REQ-019 reset=0 asynchronously forces:
- state to FETCH;
- wait counter to 0;
- cause to 00;
- trap to 0.
REQ-020 Reset during LW or SW abandons the access; first cycle after release is FETCH with mem_req=1.

Structure
REQ-021 Package mc_control_pkg holds:
- state enum;
- opcode and funct constants;
- aluop, selalu2 and cause codes.
REQ-022 The wait counter is sub-module mc_wait_timer, sized $clog2(MEM_TIMEOUT+1); its inputs are start, ack and limit, its output is expired.

Verification
REQ-023 add inst 0x012A4020, mem_ack immediate -> FETCH, DECODE, MRTYPE (aluop 0010, wreg=1), REGPCINC (wpc=1), FETCH; 5 cycles.
REQ-024 lw inst 0x8D280004, mem_ack after 3 wait cycles -> mem_req high 4 cycles in LW; wreg=1 only in the ack cycle.
REQ-025 beq 0x11090003:
- aluzero=1 -> BPCINC, selalu2=011.
- bne 0x15090003 with aluzero=1 -> REGPCINC.
REQ-026 opcode 111111 -> TRAP one cycle after DECODE; trap pulse, cause=01, selalu2=101.
REQ-027 MEM_TIMEOUT=4, mem_ack held 0 in FETCH -> TRAP after 4 wait cycles, cause=10; repeat with ack on the 4th cycle -> DECODE, no trap.
REQ-028 jal 0x0C000010 -> JAL cycle (wreg=1, selregaddr=10), then J (wpc=1); reset=0 asserted mid-LW -> FETCH immediately, wreg never asserted.
